// File: rtl/data_sram_resp.sv
// Dual-port, two-bank word SRAM with per-port request/response handshake.
// Define DATA_RESP_PIPE_EN to add an output register stage (latency 2 instead of 1).
module data_sram_resp #(
  parameter int INDEX_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_01,
  input  logic        wr_01,
  input  logic [3:0]  wstrb_01,
  input  logic [31:0] addr_01,
  input  logic [31:0] wdata_01,
  output logic        addr_ok_01,
  output logic        data_ok_01,
  output logic [31:0] rdata_01,
  input  logic        req_02,
  input  logic        wr_02,
  input  logic [3:0]  wstrb_02,
  input  logic [31:0] addr_02,
  input  logic [31:0] wdata_02,
  output logic        addr_ok_02,
  output logic        data_ok_02,
  output logic [31:0] rdata_02
);

  localparam int ROW_W = INDEX_W - 1;
  localparam int ROWS  = 1 << ROW_W;

  logic             bank_01, bank_02;
  logic [ROW_W-1:0] row_01, row_02;
  logic             same_word, conflict;
  logic             unused_addr_bits;
  logic [31:0]      bank_rd [2];

  assign bank_01   = addr_01[2];
  assign bank_02   = addr_02[2];
  assign row_01    = addr_01[INDEX_W+1:3];
  assign row_02    = addr_02[INDEX_W+1:3];
  assign same_word = (addr_01[INDEX_W+1:2] == addr_02[INDEX_W+1:2]);

  assign unused_addr_bits = ^{addr_01[31:INDEX_W+2], addr_01[1:0],
                              addr_02[31:INDEX_W+2], addr_02[1:0]};

  // Two loads of the same word share one bank read, so they never conflict.
  assign conflict   = req_01 & (bank_01 == bank_02) & ~(~wr_01 & ~wr_02 & same_word);
  assign addr_ok_01 = req_01 & ~reset;
  assign addr_ok_02 = req_02 & ~reset & ~conflict;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [31:0]      mem [ROWS];
    logic [31:0]      rd_q;
    logic             sel_01, sel_02;
    logic             acc_en, acc_we;
    logic [ROW_W-1:0] acc_row;
    logic [3:0]       acc_strb;
    logic [31:0]      acc_wdata;

    assign sel_01 = addr_ok_01 & (bank_01 == 1'(b));
    assign sel_02 = addr_ok_02 & (bank_02 == 1'(b));

    always_comb begin
      acc_en    = sel_01 | sel_02;
      acc_we    = wr_02;
      acc_row   = row_02;
      acc_strb  = wstrb_02;
      acc_wdata = wdata_02;
      if (sel_01) begin
        acc_we    = wr_01;
        acc_row   = row_01;
        acc_strb  = wstrb_01;
        acc_wdata = wdata_01;
      end
    end

    // Storage is deliberately not reset; reset only affects the handshake state.
    always_ff @(posedge clk) begin
      if (acc_en) begin
        if (acc_we) begin
          for (int n = 0; n < 4; n++) begin
            if (acc_strb[n]) mem[acc_row][n*8 +: 8] <= acc_wdata[n*8 +: 8];
          end
        end else begin
          rd_q <= mem[acc_row];
        end
      end
    end

    assign bank_rd[b] = rd_q;
  end

  logic        v1_01, v1_02;
  logic        ld1_01, ld1_02;
  logic        bk1_01, bk1_02;
  logic [31:0] d1_01, d1_02;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_01  <= 1'b0;
      v1_02  <= 1'b0;
      ld1_01 <= 1'b0;
      ld1_02 <= 1'b0;
      bk1_01 <= 1'b0;
      bk1_02 <= 1'b0;
    end else begin
      v1_01  <= addr_ok_01;
      v1_02  <= addr_ok_02;
      ld1_01 <= ~wr_01;
      ld1_02 <= ~wr_02;
      bk1_01 <= bank_01;
      bk1_02 <= bank_02;
    end
  end

  assign d1_01 = (v1_01 & ld1_01) ? bank_rd[bk1_01] : 32'h0;
  assign d1_02 = (v1_02 & ld1_02) ? bank_rd[bk1_02] : 32'h0;

`ifdef DATA_RESP_PIPE_EN
  logic        ok2_01, ok2_02;
  logic [31:0] rd2_01, rd2_02;

  always_ff @(posedge clk) begin
    if (reset) begin
      ok2_01 <= 1'b0;
      ok2_02 <= 1'b0;
      rd2_01 <= 32'h0;
      rd2_02 <= 32'h0;
    end else begin
      ok2_01 <= v1_01;
      ok2_02 <= v1_02;
      rd2_01 <= d1_01;
      rd2_02 <= d1_02;
    end
  end

  assign data_ok_01 = ok2_01 & ~reset;
  assign data_ok_02 = ok2_02 & ~reset;
  assign rdata_01   = reset ? 32'h0 : rd2_01;
  assign rdata_02   = reset ? 32'h0 : rd2_02;
`else
  // Gated by reset so a response in flight at reset assertion is suppressed at once.
  assign data_ok_01 = v1_01 & ~reset;
  assign data_ok_02 = v1_02 & ~reset;
  assign rdata_01   = reset ? 32'h0 : d1_01;
  assign rdata_02   = reset ? 32'h0 : d1_02;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed scenarios then random traffic
// checked against a word-array memory model and a per-cycle response schedule.
module tb_data_sram_resp;
  localparam int INDEX_W = 10;
`ifdef DATA_RESP_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_01, wr_01, req_02, wr_02;
  logic [3:0]  wstrb_01, wstrb_02;
  logic [31:0] addr_01, wdata_01, addr_02, wdata_02;
  logic        addr_ok_01, data_ok_01, addr_ok_02, data_ok_02;
  logic [31:0] rdata_01, rdata_02;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model_mem [64];
  logic        exp_ok1 [8];
  logic        exp_ok2 [8];
  logic [31:0] exp_rd1 [8];
  logic [31:0] exp_rd2 [8];
  logic        model_acc2 = 1'b0;

  logic        last_ack1, last_ack2, last_ok1, last_ok2;
  logic [31:0] last_rd1, last_rd2;

  data_sram_resp #(.INDEX_W(INDEX_W)) dut (
    .clk(clk), .reset(reset),
    .req_01(req_01), .wr_01(wr_01), .wstrb_01(wstrb_01), .addr_01(addr_01),
    .wdata_01(wdata_01), .addr_ok_01(addr_ok_01), .data_ok_01(data_ok_01),
    .rdata_01(rdata_01),
    .req_02(req_02), .wr_02(wr_02), .wstrb_02(wstrb_02), .addr_02(addr_02),
    .wdata_02(wdata_02), .addr_ok_02(addr_ok_02), .data_ok_02(data_ok_02),
    .rdata_02(rdata_02)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void mergeStore(input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    for (int n = 0; n < 4; n++) begin
      if (st[n]) model_mem[a[7:2]][n*8 +: 8] = d[n*8 +: 8];
    end
  endfunction

  task automatic applyStimulus(input logic r1, input logic w1, input logic [3:0] s1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic r2, input logic w2, input logic [3:0] s2,
                               input logic [31:0] a2, input logic [31:0] d2);
    req_01 = r1; wr_01 = w1; wstrb_01 = s1; addr_01 = a1; wdata_01 = d1;
    req_02 = r2; wr_02 = w2; wstrb_02 = s2; addr_02 = a2; wdata_02 = d2;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // One clock cycle: check outputs at the falling edge against the model,
  // then book the accepted requests' responses LAT cycles ahead.
  task automatic tick();
    int   s, t;
    logic conf, acc1, acc2;
    @(negedge clk);
    s = cyc % 8;
    conf = req_01 && req_02 && (addr_01[2] == addr_02[2]) &&
           !(!wr_01 && !wr_02 && (addr_01[INDEX_W+1:2] == addr_02[INDEX_W+1:2]));
    acc1 = req_01 && !reset;
    acc2 = req_02 && !reset && !conf;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        exp_ok1[k] = 1'b0; exp_ok2[k] = 1'b0; exp_rd1[k] = 32'h0; exp_rd2[k] = 32'h0;
      end
    end
    checkOutput("addr_ok_01", {31'b0, addr_ok_01}, {31'b0, acc1});
    checkOutput("addr_ok_02", {31'b0, addr_ok_02}, {31'b0, acc2});
    checkOutput("data_ok_01", {31'b0, data_ok_01}, {31'b0, exp_ok1[s]});
    checkOutput("data_ok_02", {31'b0, data_ok_02}, {31'b0, exp_ok2[s]});
    checkOutput("rdata_01", rdata_01, exp_rd1[s]);
    checkOutput("rdata_02", rdata_02, exp_rd2[s]);
    last_ack1 = addr_ok_01; last_ack2 = addr_ok_02;
    last_ok1  = data_ok_01; last_ok2  = data_ok_02;
    last_rd1  = rdata_01;   last_rd2  = rdata_02;
    exp_ok1[s] = 1'b0; exp_ok2[s] = 1'b0; exp_rd1[s] = 32'h0; exp_rd2[s] = 32'h0;
    t = (cyc + LAT) % 8;
    if (acc1) begin
      exp_ok1[t] = 1'b1;
      exp_rd1[t] = wr_01 ? 32'h0 : model_mem[addr_01[7:2]];
    end
    if (acc2) begin
      exp_ok2[t] = 1'b1;
      exp_rd2[t] = wr_02 ? 32'h0 : model_mem[addr_02[7:2]];
    end
    if (acc1 && wr_01) mergeStore(addr_01, wstrb_01, wdata_01);
    if (acc2 && wr_02) mergeStore(addr_02, wstrb_02, wdata_02);
    model_acc2 = acc2;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic        r1, w1, r2, w2;
    logic [3:0]  s1, s2;
    logic [31:0] a1, a2, d1, d2;

    for (int k = 0; k < 8; k++) begin
      exp_ok1[k] = 1'b0; exp_ok2[k] = 1'b0; exp_rd1[k] = 32'h0; exp_rd2[k] = 32'h0;
    end
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // Fill the tracked words, one per bank per cycle.
    for (int i = 0; i < 32; i++) begin
      d1 = $urandom();
      d2 = $urandom();
      applyStimulus(1'b1, 1'b1, 4'hF, 32'(i * 8), d1, 1'b1, 1'b1, 4'hF, 32'(i * 8 + 4), d2);
      tick();
    end
    idle();
    repeat (LAT) tick();

    $display("[TB] full-word store then load");
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    repeat (LAT) tick();
    checkOutput("raw_data_ok", {31'b0, last_ok1}, 32'h1);
    checkOutput("raw_rdata", last_rd1, 32'hDEADBEEF);

    $display("[TB] byte-strobe merge");
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'h2, 32'h20, 32'h0000AA00, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    repeat (LAT) tick();
    checkOutput("strobe_rdata", last_rd1, 32'h1122AA44);

    $display("[TB] parallel loads, different banks");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    tick();
    checkOutput("par_ack1", {31'b0, last_ack1}, 32'h1);
    checkOutput("par_ack2", {31'b0, last_ack2}, 32'h1);
    idle();
    repeat (LAT) tick();
    checkOutput("par_ok1", {31'b0, last_ok1}, 32'h1);
    checkOutput("par_ok2", {31'b0, last_ok2}, 32'h1);

    $display("[TB] same-bank conflict");
    applyStimulus(1'b1, 1'b1, 4'hF, 32'h8, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0, 32'h18, 32'h0);
    tick();
    checkOutput("conf_ack2_refused", {31'b0, last_ack2}, 32'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h18, 32'h0);
    tick();
    checkOutput("conf_ack2_retry", {31'b0, last_ack2}, 32'h1);
    idle();
    repeat (LAT) tick();
    checkOutput("conf_ok2", {31'b0, last_ok2}, 32'h1);

    $display("[TB] shared load of one word");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    tick();
    checkOutput("shared_ack2", {31'b0, last_ack2}, 32'h1);
    idle();
    repeat (LAT) tick();
    checkOutput("shared_rd1", last_rd1, model_mem[12]);
    checkOutput("shared_rd2", last_rd2, model_mem[12]);

    $display("[TB] reset cancels in-flight response");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    idle();
    tick();
    checkOutput("rst_ok1", {31'b0, last_ok1}, 32'h0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    checkOutput("rst_ok1_after", {31'b0, last_ok1}, 32'h0);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    repeat (LAT) tick();
    checkOutput("rst_keeps_mem", last_rd1, 32'hDEADBEEF);

    $display("[TB] back-to-back loads");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    repeat (LAT + 1) tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      r1 = ($urandom_range(0, 99) < 70);
      w1 = ($urandom_range(0, 99) < 40);
      s1 = 4'($urandom_range(0, 15));
      a1 = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      d1 = $urandom();
      if (req_02 && !model_acc2) begin
        r2 = req_02; w2 = wr_02; s2 = wstrb_02; a2 = addr_02; d2 = wdata_02;
      end else begin
        r2 = ($urandom_range(0, 99) < 70);
        w2 = ($urandom_range(0, 99) < 40);
        s2 = 4'($urandom_range(0, 15));
        a2 = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        d2 = $urandom();
      end
      reset = ($urandom_range(0, 99) < 2);
      applyStimulus(r1, w1, s1, a1, d1, r2, w2, s2, a2, d2);
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (LAT + 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
